// File: rtl/vxe_mem_hub_m_ds.sv
// Master-side downstream response buffer: splits each memory response into a status entry and (reads only) a data entry.
// Push visible one cycle after accept; o_mrsp_rdy drops when either FIFO is full and depends on registered counts only.

module vxe_mem_hub_m_ds_fifo #(
  parameter int W          = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic         vld_o,
  output logic         full_o,
  output logic [W-1:0] head_dat_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [W-1:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign vld_o      = (cnt_q != '0);
  assign full_o     = (cnt_q == (DEPTH_LOG2+1)'(DEPTH));
  assign head_dat_o = mem_q[rd_ptr_q];

  // Pop only acts on a non-empty queue, so a push into an empty queue never races a pop.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && vld_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

module vxe_mem_hub_m_ds #(
  parameter int RSS_DEPTH_LOG2 = 2,
  parameter int RSD_DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mrsp_vld,
  input  logic [5:0]  i_mrsp_cid,
  input  logic        i_mrsp_rnw,
  input  logic [1:0]  i_mrsp_err,
  input  logic [63:0] i_mrsp_data,
  output logic        o_mrsp_rdy,
  output logic        o_rss_vld,
  output logic [8:0]  o_rss,
  input  logic        i_rss_rd,
  output logic        o_rsd_vld,
  output logic [63:0] o_rsd,
  input  logic        i_rsd_rd,
  output logic        o_busy
);
  logic rss_full, rsd_full;
  logic accept;

  // Writes are refused while the data queue is full too, keeping ready independent of i_mrsp_rnw.
  assign o_mrsp_rdy = !rst && !rss_full && !rsd_full;
  assign accept     = i_mrsp_vld && o_mrsp_rdy;
  assign o_busy     = o_rss_vld || o_rsd_vld;

  vxe_mem_hub_m_ds_fifo #(
    .W          (9),
    .DEPTH_LOG2 (RSS_DEPTH_LOG2)
  ) u_rss (
    .clk        (clk),
    .rst        (rst),
    .push_i     (accept),
    .push_dat_i ({i_mrsp_cid, i_mrsp_rnw, i_mrsp_err}),
    .pop_i      (i_rss_rd),
    .vld_o      (o_rss_vld),
    .full_o     (rss_full),
    .head_dat_o (o_rss)
  );

  // Errored reads still push data so status and data counts for reads stay paired.
  vxe_mem_hub_m_ds_fifo #(
    .W          (64),
    .DEPTH_LOG2 (RSD_DEPTH_LOG2)
  ) u_rsd (
    .clk        (clk),
    .rst        (rst),
    .push_i     (accept && i_mrsp_rnw),
    .push_dat_i (i_mrsp_data),
    .pop_i      (i_rsd_rd),
    .vld_o      (o_rsd_vld),
    .full_o     (rsd_full),
    .head_dat_o (o_rsd)
  );
endmodule

// File: tb/tb_vxe_mem_hub_m_ds.sv
// Bench for vxe_mem_hub_m_ds: vector table, directed corner sequences, and random traffic against a queue model.
module tb_vxe_mem_hub_m_ds;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_mrsp_vld = 1'b0;
  logic [5:0]  i_mrsp_cid = '0;
  logic        i_mrsp_rnw = 1'b0;
  logic [1:0]  i_mrsp_err = '0;
  logic [63:0] i_mrsp_data = '0;
  logic        o_mrsp_rdy;
  logic        o_rss_vld;
  logic [8:0]  o_rss;
  logic        i_rss_rd = 1'b0;
  logic        o_rsd_vld;
  logic [63:0] o_rsd;
  logic        i_rsd_rd = 1'b0;
  logic        o_busy;

  int n_cmp = 0;
  int n_fail = 0;
  int n_dut_acc = 0;

  logic [8:0]  mq_rss[$];
  logic [63:0] mq_rsd[$];

  vxe_mem_hub_m_ds dut (
    .clk         (clk),
    .rst         (rst),
    .i_mrsp_vld  (i_mrsp_vld),
    .i_mrsp_cid  (i_mrsp_cid),
    .i_mrsp_rnw  (i_mrsp_rnw),
    .i_mrsp_err  (i_mrsp_err),
    .i_mrsp_data (i_mrsp_data),
    .o_mrsp_rdy  (o_mrsp_rdy),
    .o_rss_vld   (o_rss_vld),
    .o_rss       (o_rss),
    .i_rss_rd    (i_rss_rd),
    .o_rsd_vld   (o_rsd_vld),
    .o_rsd       (o_rsd),
    .i_rsd_rd    (i_rsd_rd),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [5:0]  cid;
    logic        rnw;
    logic [1:0]  err;
    logic [63:0] data;
    logic        rss_rd;
    logic        rsd_rd;
    logic        e_rdy;
    logic        e_rss_vld;
    logic [8:0]  e_rss;
    logic        e_rsd_vld;
    logic [63:0] e_rsd;
    logic        e_busy;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] c, input logic r, input logic [1:0] e,
                       input logic [63:0] d, input logic rr, input logic dr);
    i_mrsp_vld  = v;
    i_mrsp_cid  = c;
    i_mrsp_rnw  = r;
    i_mrsp_err  = e;
    i_mrsp_data = d;
    i_rss_rd    = rr;
    i_rsd_rd    = dr;
  endtask

  // One cycle of traffic checked against the queue model; outputs are compared before the edge.
  task automatic model_cycle(input logic v, input logic [5:0] c, input logic r, input logic [1:0] e,
                             input logic [63:0] d, input logic rr, input logic dr);
    logic exp_rdy;
    drive(v, c, r, e, d, rr, dr);
    exp_rdy = (mq_rss.size() < DEPTH) && (mq_rsd.size() < DEPTH);
    check("m_rdy", 64'(o_mrsp_rdy), 64'(exp_rdy));
    check("m_rss_vld", 64'(o_rss_vld), 64'(mq_rss.size() != 0));
    check("m_rsd_vld", 64'(o_rsd_vld), 64'(mq_rsd.size() != 0));
    check("m_busy", 64'(o_busy), 64'((mq_rss.size() != 0) || (mq_rsd.size() != 0)));
    if (mq_rss.size() != 0) check("m_rss", 64'(o_rss), 64'(mq_rss[0]));
    if (mq_rsd.size() != 0) check("m_rsd", o_rsd, mq_rsd[0]);
    if (v && o_mrsp_rdy) n_dut_acc++;
    if (rr && mq_rss.size() != 0) void'(mq_rss.pop_front());
    if (dr && mq_rsd.size() != 0) void'(mq_rsd.pop_front());
    if (v && exp_rdy) begin
      mq_rss.push_back({c, r, e});
      if (r) mq_rsd.push_back(d);
    end
    tick();
  endtask

  initial begin
    int acc0;
    // read cid 15; pop both; write cid 3 err 2; pop; underflow attempt; read cid 2A; pop
    vecs[0] = '{1'b1, 6'h15, 1'b1, 2'b00, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0,
                1'b1, 1'b1, 9'h0AC, 1'b1, 64'hDEAD_BEEF_0123_4567, 1'b1};
    vecs[1] = '{1'b0, 6'h00, 1'b0, 2'b00, 64'h0, 1'b1, 1'b1,
                1'b1, 1'b0, 9'h000, 1'b0, 64'h0, 1'b0};
    vecs[2] = '{1'b1, 6'h03, 1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
                1'b1, 1'b1, 9'h01A, 1'b0, 64'h0, 1'b1};
    vecs[3] = '{1'b0, 6'h00, 1'b0, 2'b00, 64'h0, 1'b1, 1'b0,
                1'b1, 1'b0, 9'h000, 1'b0, 64'h0, 1'b0};
    vecs[4] = '{1'b0, 6'h00, 1'b0, 2'b00, 64'h0, 1'b1, 1'b1,
                1'b1, 1'b0, 9'h000, 1'b0, 64'h0, 1'b0};
    vecs[5] = '{1'b1, 6'h2A, 1'b1, 2'b00, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0,
                1'b1, 1'b1, 9'h154, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1};
    vecs[6] = '{1'b0, 6'h00, 1'b0, 2'b00, 64'h0, 1'b1, 1'b1,
                1'b1, 1'b0, 9'h000, 1'b0, 64'h0, 1'b0};

    tick();
    tick();
    check("rst_rdy", 64'(o_mrsp_rdy), 64'd0);
    check("rst_rss_vld", 64'(o_rss_vld), 64'd0);
    check("rst_rsd_vld", 64'(o_rsd_vld), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_rdy", 64'(o_mrsp_rdy), 64'd1);

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].vld, vecs[i].cid, vecs[i].rnw, vecs[i].err, vecs[i].data,
            vecs[i].rss_rd, vecs[i].rsd_rd);
      tick();
      check($sformatf("vec%0d_rdy", i), 64'(o_mrsp_rdy), 64'(vecs[i].e_rdy));
      check($sformatf("vec%0d_rss_vld", i), 64'(o_rss_vld), 64'(vecs[i].e_rss_vld));
      check($sformatf("vec%0d_rsd_vld", i), 64'(o_rsd_vld), 64'(vecs[i].e_rsd_vld));
      check($sformatf("vec%0d_busy", i), 64'(o_busy), 64'(vecs[i].e_busy));
      if (vecs[i].e_rss_vld) check($sformatf("vec%0d_rss", i), 64'(o_rss), 64'(vecs[i].e_rss));
      if (vecs[i].e_rsd_vld) check($sformatf("vec%0d_rsd", i), o_rsd, vecs[i].e_rsd);
    end

    // Fill to full, hold a 5th read under backpressure, free one slot, then drain.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 6'(i), 1'b1, 2'b00, 64'hA000 + 64'(i), 1'b0, 1'b0);
      tick();
      check($sformatf("fill%0d_rdy", i), 64'(o_mrsp_rdy), 64'(i < 3));
    end
    drive(1'b1, 6'd4, 1'b1, 2'b00, 64'hA004, 1'b0, 1'b0);
    tick();
    check("fill_hold_rdy", 64'(o_mrsp_rdy), 64'd0);
    check("fill_hold_head", 64'(o_rss), 64'({6'd0, 1'b1, 2'b00}));
    drive(1'b1, 6'd4, 1'b1, 2'b00, 64'hA004, 1'b1, 1'b1);
    tick();
    check("fill_pop_rdy", 64'(o_mrsp_rdy), 64'd1);
    check("fill_pop_head", 64'(o_rss), 64'({6'd1, 1'b1, 2'b00}));
    drive(1'b1, 6'd4, 1'b1, 2'b00, 64'hA004, 1'b0, 1'b0);
    tick();
    check("fill_refull_rdy", 64'(o_mrsp_rdy), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 6'd0, 1'b0, 2'b00, 64'h0, 1'b1, 1'b1);
      check($sformatf("fill_drain%0d_rss", k), 64'(o_rss), 64'({6'(k), 1'b1, 2'b00}));
      check($sformatf("fill_drain%0d_rsd", k), o_rsd, 64'hA000 + 64'(k));
      tick();
    end
    check("fill_empty_busy", 64'(o_busy), 64'd0);

    // Data queue full but status not: a write must still wait for a data pop.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 6'(8 + i), 1'b1, 2'b00, 64'hB000 + 64'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 6'd0, 1'b0, 2'b00, 64'h0, 1'b1, 1'b0);
    tick();
    check("asym_rdy0", 64'(o_mrsp_rdy), 64'd0);
    drive(1'b1, 6'h3F, 1'b0, 2'b01, 64'h0, 1'b0, 1'b0);
    tick();
    tick();
    check("asym_rdy1", 64'(o_mrsp_rdy), 64'd0);
    drive(1'b1, 6'h3F, 1'b0, 2'b01, 64'h0, 1'b0, 1'b1);
    tick();
    check("asym_rdy2", 64'(o_mrsp_rdy), 64'd1);
    drive(1'b1, 6'h3F, 1'b0, 2'b01, 64'h0, 1'b0, 1'b0);
    tick();
    check("asym_rdy3", 64'(o_mrsp_rdy), 64'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 6'd0, 1'b0, 2'b00, 64'h0, 1'b1, 1'b1);
      check($sformatf("asym_drain%0d_rss", k), 64'(o_rss),
            (k < 3) ? 64'({6'(9 + k), 1'b1, 2'b00}) : 64'({6'h3F, 1'b0, 2'b01}));
      check($sformatf("asym_drain%0d_rsd_vld", k), 64'(o_rsd_vld), 64'(k < 3));
      if (k < 3) check($sformatf("asym_drain%0d_rsd", k), o_rsd, 64'hB001 + 64'(k));
      tick();
    end
    check("asym_empty_busy", 64'(o_busy), 64'd0);

    // Streaming with both reads held high: one in, one out per cycle across pointer wrap.
    acc0 = n_dut_acc;
    for (int i = 0; i < 16; i++)
      model_cycle(1'b1, 6'(i), 1'b1, 2'b00, {32'hC0DE_0000, 32'(i)}, 1'b1, 1'b1);
    model_cycle(1'b0, 6'd0, 1'b0, 2'b00, 64'h0, 1'b1, 1'b1);
    check("stream_accepts", 64'(n_dut_acc - acc0), 64'd16);
    model_cycle(1'b0, 6'd0, 1'b0, 2'b00, 64'h0, 1'b0, 1'b0);

    // Asynchronous reset with entries queued.
    for (int i = 0; i < 3; i++)
      model_cycle(1'b1, 6'(20 + i), 1'b1, 2'b00, 64'hE000 + 64'(i), 1'b0, 1'b0);
    drive(1'b0, 6'd0, 1'b0, 2'b00, 64'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_rss_vld", 64'(o_rss_vld), 64'd0);
    check("mid_rst_rsd_vld", 64'(o_rsd_vld), 64'd0);
    check("mid_rst_rdy", 64'(o_mrsp_rdy), 64'd0);
    check("mid_rst_busy", 64'(o_busy), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("after_rst_rdy", 64'(o_mrsp_rdy), 64'd1);
    check("after_rst_rss_vld", 64'(o_rss_vld), 64'd0);
    mq_rss.delete();
    mq_rsd.delete();
    model_cycle(1'b1, 6'h2A, 1'b1, 2'b00, 64'h5555_AAAA_1234_5678, 1'b0, 1'b0);
    check("after_rst_head", 64'(o_rss), 64'h154);
    check("after_rst_data", o_rsd, 64'h5555_AAAA_1234_5678);
    model_cycle(1'b0, 6'd0, 1'b0, 2'b00, 64'h0, 1'b1, 1'b1);

    // Random traffic: a slow-consumer phase to exercise full, then a fast one.
    for (int i = 0; i < 600; i++) begin
      int rd_pct;
      rd_pct = (i < 300) ? 30 : 75;
      model_cycle(($urandom_range(99) < 70), 6'($urandom), 1'($urandom), 2'($urandom),
                  {$urandom, $urandom},
                  ($urandom_range(99) < rd_pct), ($urandom_range(99) < rd_pct));
    end
    for (int i = 0; i < 6; i++)
      model_cycle(1'b0, 6'd0, 1'b0, 2'b00, 64'h0, 1'b1, 1'b1);
    check("final_busy", 64'(o_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
